// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: opcode values, instruction field layout
// and loader FSM encodings.
package program_loader_pkg;

    localparam int DEPTH_DEF   = 8;
    localparam int INSTR_W_DEF = 20;
    localparam int PC_W_DEF    = 4;

    localparam logic [3:0] OP_STOP = 4'hF;

    localparam int OPC_MSB   = 19;
    localparam int OPND1_MSB = 15;
    localparam int OPND2_MSB = 7;

    localparam logic [INSTR_W_DEF-1:0] STOP_INSTR = {OP_STOP, 16'h0000};

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_OP     = 3'd1,
        LD_OPND1  = 3'd2,
        LD_OPND2  = 3'd3,
        LD_COMMIT = 3'd4,
        LD_DONE   = 3'd5
    } ld_state_t;

    function automatic logic [INSTR_W_DEF-1:0] pack_instr(
        input logic [3:0] opc,
        input logic [7:0] opnd1,
        input logic [7:0] opnd2
    );
        logic [INSTR_W_DEF-1:0] instr;
        instr                          = '0;
        instr[OPC_MSB   -: 4]          = opc;
        instr[OPND1_MSB -: 8]          = opnd1;
        instr[OPND2_MSB -: 8]          = opnd2;
        return instr;
    endfunction

endpackage

// File: rtl/program_loader_store.sv
// Instruction store: register array with per-slot valid bits. Unwritten or
// out-of-range slots read back as a STOP instruction.
module program_loader_store
    import program_loader_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [PC_W-1:0]    rd_addr,
    output logic [INSTR_W-1:0] rd_instr
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   valid_reg;

    // Only the valid bits are reset; stale data behind a cleared bit is never visible.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                end else if (clear) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    logic [ADDR_W-1:0] rd_idx;
    logic              rd_hit;

    always_comb begin
        rd_idx   = rd_addr[ADDR_W-1:0];
        rd_hit   = (rd_addr < PC_W'(DEPTH)) && valid_reg[rd_idx];
        rd_instr = rd_hit ? mem[rd_idx] : INSTR_W'(STOP_INSTR);
    end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 3-byte instructions, commits them into the
// instruction store and holds the CPU until the program is complete.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    output logic               in_ready,
    input  logic [PC_W-1:0]    rd_addr,
    output logic [INSTR_W-1:0] rd_instr,
    output logic [PC_W-1:0]    instr_count,
    output logic               load_done,
    output logic               cpu_hold,
    output logic               err_frame
);

    localparam int ADDR_W = $clog2(DEPTH);

    ld_state_t         state_reg, state_next;
    logic [3:0]        opcode_reg, opcode_next;
    logic [7:0]        opnd1_reg, opnd1_next;
    logic [7:0]        opnd2_reg, opnd2_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PC_W-1:0]   count_reg, count_next;
    logic              err_reg, err_next;
    logic              ready_reg, ready_next;
    logic              done_reg, done_next;
    logic              hold_reg, hold_next;
    logic              store_clear, store_wr;
    logic              xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= LD_IDLE;
            opcode_reg <= '0;
            opnd1_reg  <= '0;
            opnd2_reg  <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
            ready_reg  <= 1'b0;
            done_reg   <= 1'b0;
            hold_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            opnd1_reg  <= opnd1_next;
            opnd2_reg  <= opnd2_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
            hold_reg   <= hold_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        opnd1_next  = opnd1_reg;
        opnd2_next  = opnd2_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        store_clear = 1'b0;
        store_wr    = 1'b0;
        xfer        = in_valid && ready_reg;

        case (state_reg)
            LD_IDLE, LD_DONE: begin
                if (load_start) begin
                    state_next  = LD_OP;
                    store_clear = 1'b1;
                    wr_ptr_next = '0;
                    count_next  = '0;
                    err_next    = 1'b0;
                end
            end
            LD_OP: begin
                if (xfer) begin
                    // A malformed opcode byte is dropped so the stream can resync on the next one.
                    if (in_byte[7:4] != 4'h0) begin
                        err_next = 1'b1;
                    end else begin
                        opcode_next = in_byte[3:0];
                        state_next  = LD_OPND1;
                    end
                end
            end
            LD_OPND1: begin
                if (xfer) begin
                    opnd1_next = in_byte;
                    state_next = LD_OPND2;
                end
            end
            LD_OPND2: begin
                if (xfer) begin
                    opnd2_next = in_byte;
                    state_next = LD_COMMIT;
                end
            end
            LD_COMMIT: begin
                store_wr    = 1'b1;
                wr_ptr_next = wr_ptr_reg + 1'b1;
                count_next  = count_reg + 1'b1;
                if ((opcode_reg == OP_STOP) || (wr_ptr_reg == ADDR_W'(DEPTH - 1))) begin
                    state_next = LD_DONE;
                end else begin
                    state_next = LD_OP;
                end
            end
            default: state_next = LD_IDLE;
        endcase

        // Output flags are registered decodes of the state being entered.
        ready_next = (state_next == LD_OP) || (state_next == LD_OPND1) || (state_next == LD_OPND2);
        done_next  = (state_next == LD_DONE);
        hold_next  = (state_next != LD_DONE);
    end

    program_loader_store #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .ADDR_W  (ADDR_W)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (store_clear),
        .wr_en    (store_wr),
        .wr_addr  (wr_ptr_reg),
        .wr_data  (INSTR_W'(pack_instr(opcode_reg, opnd1_reg, opnd2_reg))),
        .rd_addr  (rd_addr),
        .rd_instr (rd_instr)
    );

    assign in_ready    = ready_reg;
    assign instr_count = count_reg;
    assign load_done   = done_reg;
    assign cpu_hold    = hold_reg;
    assign err_frame   = err_reg;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a reference model turns each byte
// stream into the expected program image, checked by a monitor when a load completes.
`timescale 1ns/10ps
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic [3:0]  rd_addr = 4'h0;
    logic [19:0] rd_instr;
    logic [3:0]  instr_count;
    logic        load_done;
    logic        cpu_hold;
    logic        err_frame;

    program_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .rd_addr     (rd_addr),
        .rd_instr    (rd_instr),
        .instr_count (instr_count),
        .load_done   (load_done),
        .cpu_hold    (cpu_hold),
        .err_frame   (err_frame)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] byte_q_t [$];

    typedef struct packed {
        logic [15:0][19:0] image;
        logic [3:0]        count;
        logic              err;
        logic              done;
        logic [31:0]       consumed;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;
    bit   snap_req = 1'b0;
    bit   ld_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the stream as opcode/operand triples, drop bad opcodes,
    // stop after a STOP instruction or once 8 instructions exist.
    function automatic exp_t model(input byte_q_t b);
        exp_t e;
        int   phase = 0;
        int   n = 0;
        logic [3:0] opc = 4'h0;
        logic [7:0] o1 = 8'h00;
        e = '0;
        for (int a = 0; a < 16; a++) e.image[a] = 20'hF0000;
        for (int i = 0; i < b.size(); i++) begin
            if (e.done) break;
            e.consumed++;
            if (phase == 0) begin
                if (b[i][7:4] != 4'h0) e.err = 1'b1;
                else begin opc = b[i][3:0]; phase = 1; end
            end else if (phase == 1) begin
                o1 = b[i]; phase = 2;
            end else begin
                e.image[n] = {opc, o1, b[i]};
                n++;
                phase = 0;
                if (opc == 4'hF || n == 8) e.done = 1'b1;
            end
        end
        e.count = 4'(n);
        return e;
    endfunction

    // Monitor: on each completed load (or explicit snapshot request) compare the whole image.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((load_done && !ld_prev) || snap_req) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("instr_count", 32'(instr_count), 32'(e.count));
                    chk("err_frame", 32'(err_frame), 32'(e.err));
                    chk("load_done", 32'(load_done), 32'(e.done));
                    chk("cpu_hold", 32'(cpu_hold), 32'(!e.done));
                    for (int a = 0; a < 16; a++) begin
                        rd_addr = 4'(a);
                        #0.1;
                        chk($sformatf("rd_instr[%0d]", a), 32'(rd_instr), 32'(e.image[a]));
                    end
                end
                snap_req = 1'b0;
            end
            ld_prev = load_done;
        end
    end

    task automatic wait_sb_empty();
        int guard = 0;
        while ((sb.size() != 0 || snap_req) && guard < 50) begin
            @(negedge clk); guard++;
        end
        chk("sb_drain_timeout", 32'(guard >= 50), 32'd0);
        @(negedge clk);
    endtask

    // mode: 0 = in_valid always high, 1 = every other cycle, 2 = random.
    task automatic run_load(input byte_q_t b, input int mode, input bit spurious);
        exp_t e;
        int idx = 0, cyc = 0, phase = 0, accepted = 0;
        bit v, rdy;
        e = model(b);
        sb.push_back(e);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        while (!load_done && idx < b.size() && cyc < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            in_valid   = v;
            in_byte    = b[idx];
            load_start = spurious && (phase == 1);
            rdy        = in_ready;
            @(negedge clk);
            cyc++;
            load_start = 1'b0;
            if (v && rdy) begin
                accepted++;
                if (phase == 0 && b[idx][7:4] != 4'h0) begin
                    chk("drop_stays_op_ready", 32'(in_ready), 32'd1);
                    chk("drop_err_frame", 32'(err_frame), 32'd1);
                end else begin
                    phase = (phase + 1) % 3;
                    if (phase == 0) begin
                        chk("commit_ready_low", 32'(in_ready), 32'd0);
                        chk("commit_cpu_hold", 32'(cpu_hold), 32'd1);
                    end
                end
                idx++;
            end
        end
        in_valid = 1'b0;
        cyc = 0;
        while (!load_done && cyc < 20) begin @(negedge clk); cyc++; end
        chk("load_done_timeout", 32'(load_done), 32'd1);
        // Bytes offered in DONE must not be taken.
        in_valid = 1'b1;
        in_byte  = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("done_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("bytes_accepted", 32'(accepted), e.consumed);
        wait_sb_empty();
    endtask

    function automatic byte_q_t gen_random();
        byte_q_t q;
        int n = 0;
        logic [3:0] opc;
        forever begin
            if ($urandom_range(0, 9) == 0) q.push_back({4'($urandom_range(1, 15)), 4'($urandom)});
            opc = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            q.push_back({4'h0, opc});
            q.push_back(8'($urandom));
            q.push_back(8'($urandom));
            n++;
            if (opc == 4'hF || n == 8) break;
        end
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        byte_q_t b;
        exp_t    e;
        int      acc, guard;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_instr_count", 32'(instr_count), 32'd0);
        chk("rst_err_frame", 32'(err_frame), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-instruction program ending in STOP
        b = '{8'h01, 8'h02, 8'h05, 8'h0F, 8'h00, 8'h00};
        run_load(b, 0, 1'b0);

        // Full eight non-STOP instructions plus a 25th byte
        b = {};
        for (int i = 0; i < 8; i++) begin
            b.push_back({4'h0, 4'($urandom_range(0, 14))});
            b.push_back(8'($urandom));
            b.push_back(8'($urandom));
        end
        b.push_back(8'h3C);
        run_load(b, 0, 1'b0);

        // Reload from DONE with one instruction; spurious load_start in OPND1
        b = '{8'h0F, 8'h12, 8'h34};
        run_load(b, 2, 1'b1);

        // Malformed opcode byte dropped, then a clean instruction
        b = '{8'h31, 8'h01, 8'h07, 8'h08, 8'h0F, 8'h00, 8'h00};
        run_load(b, 0, 1'b0);

        // in_valid toggling every other cycle
        b = '{8'h02, 8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h0F, 8'h9, 8'h1};
        run_load(b, 1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            b = gen_random();
            run_load(b, 2, 1'($urandom_range(0, 1)));
        end

        // Async reset after 4 bytes (one instruction committed, one byte pending)
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        b = '{8'h04, 8'h10, 8'h20, 8'h05};
        acc = 0; guard = 0;
        while (acc < 4 && guard < 20) begin
            in_valid = 1'b1;
            in_byte  = b[acc];
            if (in_ready) begin @(negedge clk); acc++; end
            else @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(instr_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_count", 32'(instr_count), 32'd0);
        e = model('{});
        sb.push_back(e);
        snap_req = 1'b1;
        wait_sb_empty();
        rst_n = 1'b1;

        // Fresh load after reset
        b = gen_random();
        run_load(b, 0, 1'b0);

        wait_sb_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
